onebit_core_gen2: RTL and testbench

ONEBIT_CORE_GEN2 -- requirements
Module: onebit_core_gen2

---
 rtl/onebit_core_gen2.sv | 114 +++++++++++
 tb/tb_onebit_core_gen2.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/onebit_core_gen2.sv
// One-bit programmable controller: serially loaded program memory, single-bit
// accumulator, bit-addressable input/output space, one instruction per executing cycle.
module onebit_core_gen2 #(
   parameter int unsigned N_IN  = 2,
   parameter int unsigned N_OUT = 7,
   parameter int unsigned DEPTH = 16
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     load_en,
   input  logic                     load_bit,
   input  logic                     run,
   input  logic                     step_mode,
   input  logic                     step,
   input  logic [N_IN-1:0]          inReg,
   output logic [N_OUT-1:0]         outReg,
   output logic [$clog2(DEPTH)-1:0] pc,
   output logic                     acc,
   output logic                     load_word_done
);

   localparam int unsigned NB = N_IN + N_OUT;
   localparam int unsigned AW = $clog2(NB);
   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned IW = 3 + AW + PW;
   localparam int unsigned CW = $clog2(IW);

   typedef enum logic [2:0] {
      OP_NOP, OP_LD, OP_ST, OP_AND, OP_OR, OP_XOR, OP_BZ, OP_JMP
   } op_t;

   logic [IW-1:0]     r_mem [DEPTH];
   logic [IW-2:0]     r_shift;
   logic [CW-1:0]     r_bitcnt;
   logic [PW-1:0]     r_load_ptr;
   logic [PW-1:0]     r_pc;
   logic              r_acc;
   logic              r_done;
   logic [N_OUT-1:0]  r_out;

   logic [IW-1:0]     w_instr;
   logic [IW-1:0]     w_word;
   op_t               w_op;
   logic [AW-1:0]     w_opr;
   logic [PW-1:0]     w_tgt;
   logic [PW-1:0]     w_pc_inc;
   logic [2**AW-1:0]  w_bits;
   logic              w_bit;
   logic              w_exec;

   // Bit space padded to a power of two so unmapped addresses read as 0.
   always_comb begin
      w_instr           = r_mem[r_pc];
      w_op              = op_t'(w_instr[IW-1 -: 3]);
      w_opr             = w_instr[PW +: AW];
      w_tgt             = w_instr[PW-1:0];
      w_bits            = '0;
      w_bits[N_IN-1:0]  = inReg;
      w_bits[NB-1:N_IN] = r_out;
      w_bit             = w_bits[w_opr];
      w_exec            = !load_en && run && (!step_mode || step);
      w_pc_inc          = r_pc + PW'(1);
      w_word            = {r_shift, load_bit};
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         for (int unsigned i = 0; i < DEPTH; i++) r_mem[i] <= '0;
         r_shift    <= '0;
         r_bitcnt   <= '0;
         r_load_ptr <= '0;
         r_pc       <= '0;
         r_acc      <= 1'b0;
         r_done     <= 1'b0;
         r_out      <= '0;
      end else if (load_en) begin
         r_shift <= w_word[IW-2:0];
         if (r_bitcnt == CW'(IW - 1)) begin
            r_mem[r_load_ptr] <= w_word;
            r_load_ptr        <= r_load_ptr + PW'(1);
            r_bitcnt          <= '0;
            r_done            <= 1'b1;
         end else begin
            r_bitcnt <= r_bitcnt + CW'(1);
            r_done   <= 1'b0;
         end
      end else begin
         r_bitcnt <= '0;
         r_done   <= 1'b0;
         if (w_exec) begin
            r_pc <= w_pc_inc;
            case (w_op)
               OP_LD:  r_acc <= w_bit;
               OP_ST: begin
                  for (int unsigned i = 0; i < N_OUT; i++)
                     if (32'(w_opr) == N_IN + i) r_out[i] <= r_acc;
               end
               OP_AND: r_acc <= r_acc & w_bit;
               OP_OR:  r_acc <= r_acc | w_bit;
               OP_XOR: r_acc <= r_acc ^ w_bit;
               OP_BZ:  if (!w_bit) r_pc <= w_tgt;
               OP_JMP: r_pc <= w_tgt;
               default: ;
            endcase
         end
      end
   end

   assign outReg         = r_out;
   assign pc             = r_pc;
   assign acc            = r_acc;
   assign load_word_done = r_done;

endmodule

// File: tb/tb_onebit_core_gen2.sv
// Bench for onebit_core_gen2: directed program scenarios plus randomized traffic,
// checked every cycle against an instruction-level model of the controller.
module tb_onebit_core_gen2;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       load_en = 1'b0;
   logic       load_bit = 1'b0;
   logic       run = 1'b0;
   logic       step_mode = 1'b0;
   logic       step = 1'b0;
   logic [1:0] inReg = 2'b00;
   logic [6:0] outReg;
   logic [3:0] pc;
   logic       acc;
   logic       load_word_done;

   int n_tests = 0;
   int n_fail  = 0;
   bit chk_en  = 1'b0;

   // Model state: program words, pc, accumulator, output bits, loader.
   int m_mem [16];
   int m_pc = 0, m_acc = 0, m_out = 0, m_lp = 0, m_cnt = 0, m_shift = 0, m_done = 0;

   always #5 clk = ~clk;

   onebit_core_gen2 #(.N_IN(2), .N_OUT(7), .DEPTH(16)) dut (
      .clk            (clk),
      .reset          (reset),
      .load_en        (load_en),
      .load_bit       (load_bit),
      .run            (run),
      .step_mode      (step_mode),
      .step           (step),
      .inReg          (inReg),
      .outReg         (outReg),
      .pc             (pc),
      .acc            (acc),
      .load_word_done (load_word_done)
   );

   task automatic chk(input string name, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic void model_step();
      int instr, op, opr, tgt, b, nxt;
      if (!reset) begin
         foreach (m_mem[i]) m_mem[i] = 0;
         m_pc = 0; m_acc = 0; m_out = 0; m_lp = 0; m_cnt = 0; m_done = 0;
         return;
      end
      if (load_en) begin
         m_shift = ((m_shift << 1) | int'(load_bit)) & 'h7FF;
         m_cnt++;
         m_done = 0;
         if (m_cnt == 11) begin
            m_mem[m_lp] = m_shift;
            m_lp   = (m_lp + 1) % 16;
            m_cnt  = 0;
            m_done = 1;
         end
         return;
      end
      m_cnt  = 0;
      m_done = 0;
      if (!run || (step_mode && !step)) return;
      instr = m_mem[m_pc];
      op    = instr >> 8;
      opr   = (instr >> 4) & 15;
      tgt   = instr & 15;
      if (opr < 2)      b = (int'(inReg) >> opr) & 1;
      else if (opr < 9) b = (m_out >> (opr - 2)) & 1;
      else              b = 0;
      nxt = (m_pc + 1) % 16;
      case (op)
         1: m_acc = b;
         2: if (opr >= 2 && opr < 9)
               m_out = (m_out & ~(1 << (opr - 2))) | (m_acc << (opr - 2));
         3: m_acc = m_acc & b;
         4: m_acc = m_acc | b;
         5: m_acc = m_acc ^ b;
         6: if (b == 0) nxt = tgt;
         7: nxt = tgt;
         default: ;
      endcase
      m_pc = nxt;
   endfunction

   always @(posedge clk) model_step();

   always @(negedge clk) begin
      if (chk_en) begin
         chk("outReg", int'(outReg), m_out);
         chk("pc", int'(pc), m_pc);
         chk("acc", int'(acc), m_acc);
         chk("load_word_done", int'(load_word_done), m_done);
      end
   end

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   // Shifts one word MSB first; checks the done pulse lands only after the last bit.
   task automatic load_word(input int w);
      for (int i = 10; i >= 0; i--) begin
         load_en  = 1'b1;
         load_bit = w[i];
         tick();
         chk("ld_pulse", int'(load_word_done), (i == 0) ? 1 : 0);
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      int chg, prev;
      tick();
      tick();
      reset  = 1'b1;
      chk_en = 1'b1;

      repeat (40) begin
         load_en = ($urandom_range(0, 3) == 0); load_bit = 1'($urandom);
         run = 1'($urandom); step_mode = 1'($urandom); step = 1'($urandom);
         inReg = 2'($urandom);
         tick();
      end
      reset = 1'b0;
      tick();
      reset = 1'b1; load_en = 0; run = 0; step_mode = 0; step = 0; inReg = 0;
      chk("rst_out", int'(outReg), 0);
      chk("rst_pc", int'(pc), 0);
      chk("rst_acc", int'(acc), 0);
      chk("rst_done", int'(load_word_done), 0);

      run = 1'b1;
      tick(); chk("nop_pc1", int'(pc), 1);
      tick(); chk("nop_pc2", int'(pc), 2);
      chk("nop_out", int'(outReg), 0);
      repeat (14) tick();
      chk("pc_wrap", int'(pc), 0);
      run = 1'b0;

      load_word('h100);
      load_word('h220);
      load_word('h700);
      load_en = 1'b0;
      tick();
      chk("mdl_mem0", m_mem[0], 'h100);
      chk("mdl_mem1", m_mem[1], 'h220);
      chk("mdl_mem2", m_mem[2], 'h700);

      inReg = 2'b01; run = 1'b1;
      tick(); chk("run_pc1", int'(pc), 1); chk("run_out_early", int'(outReg[0]), 0);
      tick(); chk("run_pc2", int'(pc), 2); chk("run_out_set", int'(outReg[0]), 1);
      tick(); chk("run_pc0", int'(pc), 0);
      inReg = 2'b00;
      repeat (3) tick();
      chk("run_out_clr", int'(outReg[0]), 0);
      run = 1'b0;

      repeat (13) load_word(0);
      load_word('h610);
      load_en = 1'b0;
      tick();
      chk("mdl_overwrite0", m_mem[0], 'h610);
      chk("mdl_mem15", m_mem[15], 0);

      inReg = 2'b00; run = 1'b1;
      repeat (20) tick();
      for (int i = 0; i < 10; i++) begin
         tick();
         chk("bz_hold", int'(pc), 0);
      end
      inReg = 2'b10;
      tick();
      chk("bz_fall", int'(pc), 1);

      step_mode = 1'b1;
      chg  = 0;
      prev = int'(pc);
      for (int i = 0; i < 20; i++) begin
         step = (i == 3 || i == 9 || i == 15);
         tick();
         if (int'(pc) != prev) chg++;
         prev = int'(pc);
      end
      step = 1'b0;
      chk("step_count", chg, 3);
      chk("step_pc", int'(pc), 1);
      step_mode = 1'b0; run = 1'b0;

      for (int i = 0; i < 5; i++) begin
         load_en = 1'b1; load_bit = 1'($urandom);
         tick();
      end
      reset = 1'b0;
      tick();
      reset = 1'b1;
      load_word('h100);
      load_en = 1'b0;
      tick();
      chk("mdl_partial_mem0", m_mem[0], 'h100);
      chk("mdl_partial_mem1", m_mem[1], 0);

      inReg = 2'b01; run = 1'b1;
      tick(); chk("mr_pc1", int'(pc), 1); chk("mr_acc", int'(acc), 1);
      tick(); chk("mr_pc2", int'(pc), 2);
      for (int i = 0; i < 5; i++) begin
         load_en = 1'b1; load_bit = 1'($urandom);
         tick();
         chk("mr_frozen", int'(pc), 2);
      end
      load_en = 1'b0;
      tick();
      chk("mr_resume", int'(pc), 3);

      for (int k = 0; k < 150; k++) begin
         if ($urandom_range(0, 1) == 0) begin
            int w, nb;
            w  = $urandom_range(0, 'h7FF);
            nb = ($urandom_range(0, 5) == 0) ? $urandom_range(1, 10) : 11;
            for (int i = 10; i > 10 - nb; i--) begin
               load_en = 1'b1; load_bit = w[i];
               run = 1'($urandom); inReg = 2'($urandom);
               tick();
            end
            load_en = 1'b0;
         end else begin
            repeat ($urandom_range(5, 25)) begin
               reset     = ($urandom_range(0, 99) != 0);
               run       = ($urandom_range(0, 4) != 0);
               step_mode = ($urandom_range(0, 3) == 0);
               step      = 1'($urandom);
               inReg     = 2'($urandom);
               load_bit  = 1'($urandom);
               tick();
            end
            reset = 1'b1;
         end
      end

      chk_en = 1'b0;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
